// File: rtl/assoc_dcache.sv
// rtl/assoc_dcache.sv - set-associative write-back, write-allocate data cache
// Define TARTARUGA_DCACHE_PLRU_EN for per-set tree pseudo-LRU; default is a global round-robin victim counter.
module assoc_dcache #(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_wr_i,
  input  logic                 we_i,
  input  logic                 valid_i,
  output logic [31:0]          data_rd_o,
  output logic                 ready_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_we_o,
  output logic [LINE_BITS-1:0] mem_data_wr_o,
  input  logic [LINE_BITS-1:0] mem_data_line_i,
  input  logic                 mem_rsp_valid_i,
  output logic                 mem_rsp_ready_o
);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int WSEL_W = $clog2(LINE_BITS / 32);

  typedef enum logic [1:0] {IDLE, WB_REQ, REFILL_REQ, REFILL_WAIT} state_t;

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] line_q  [NUM_SETS][NUM_WAYS];

  state_t               state_q, state_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic [31-OFF_W:0]    miss_addr_q, miss_addr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_wr_q, mem_data_wr_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_req_valid_q, mem_req_valid_d;
  logic                 mem_rsp_ready_q, mem_rsp_ready_d;

  logic [IDX_W-1:0]     req_idx, miss_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [WSEL_W-1:0]    req_word;
  logic [WAY_W-1:0]     hit_way, inv_way, pol_way, victim;
  logic                 hit_any, hit, inv_found, install;
  logic [LINE_BITS-1:0] hit_line;
  logic                 unused_addr_bits;

  assign req_idx          = addr_i[OFF_W +: IDX_W];
  assign req_tag          = addr_i[31 -: TAG_W];
  assign req_word         = addr_i[OFF_W-1:2];
  assign miss_idx         = miss_addr_q[IDX_W-1:0];
  assign unused_addr_bits = ^addr_i[1:0];

  always_comb begin
    hit_way   = '0;
    hit_any   = 1'b0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : pol_way;
  end

  assign hit       = valid_i && (state_q == IDLE) && hit_any;
  assign hit_line  = line_q[req_idx][hit_way];
  assign ready_o   = hit;
  assign data_rd_o = hit ? hit_line[{req_word, 5'b0} +: 32] : 32'h0;

`ifdef TARTARUGA_DCACHE_PLRU_EN
  logic [NUM_WAYS-2:0] plru_q [NUM_SETS];

  // Tree bit 0 points at the lower half, 1 at the upper half; node n has children 2n+1 and 2n+2.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
    int   node;
    logic b;
    plru_victim = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < NUM_WAYS - 1; n++) if (n == node) b = t[n];
      plru_victim = (plru_victim << 1) | WAY_W'(b);
      node = 2 * node + (b ? 2 : 1);
    end
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t,
                                                     input logic [WAY_W-1:0] way);
    int               node;
    logic             b;
    logic [WAY_W-1:0] w;
    plru_touch = t;
    node = 0;
    w = way;
    for (int l = 0; l < WAY_W; l++) begin
      b = w[WAY_W-1];
      for (int n = 0; n < NUM_WAYS - 1; n++) if (n == node) plru_touch[n] = ~b;
      node = 2 * node + (b ? 2 : 1);
      w = w << 1;
    end
  endfunction

  assign pol_way = plru_victim(plru_q[req_idx]);
`else
  logic [WAY_W-1:0] rr_q;

  assign pol_way = rr_q;
`endif

  // Memory-side outputs are registered, so they are computed for the state being entered.
  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    miss_addr_d     = miss_addr_q;
    mem_addr_d      = mem_addr_q;
    mem_data_wr_d   = mem_data_wr_q;
    mem_we_d        = mem_we_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_rsp_ready_d = mem_rsp_ready_q;
    install         = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !hit_any) begin
          victim_d        = victim;
          miss_addr_d     = addr_i[31:OFF_W];
          mem_req_valid_d = 1'b1;
          if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
            state_d       = WB_REQ;
            mem_we_d      = 1'b1;
            mem_addr_d    = {tag_q[req_idx][victim], req_idx, {OFF_W{1'b0}}};
            mem_data_wr_d = line_q[req_idx][victim];
          end else begin
            state_d       = REFILL_REQ;
            mem_we_d      = 1'b0;
            mem_addr_d    = {addr_i[31:OFF_W], {OFF_W{1'b0}}};
            mem_data_wr_d = '0;
          end
        end
      end
      WB_REQ: begin
        if (mem_req_ready_i) begin
          state_d       = REFILL_REQ;
          mem_we_d      = 1'b0;
          mem_addr_d    = {miss_addr_q, {OFF_W{1'b0}}};
          mem_data_wr_d = '0;
        end
      end
      REFILL_REQ: begin
        if (mem_req_ready_i) begin
          state_d         = REFILL_WAIT;
          mem_req_valid_d = 1'b0;
          mem_rsp_ready_d = 1'b1;
        end
      end
      default: begin
        if (mem_rsp_valid_i) begin
          install         = 1'b1;
          state_d         = IDLE;
          mem_rsp_ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      victim_q        <= '0;
      miss_addr_q     <= '0;
      mem_addr_q      <= '0;
      mem_data_wr_q   <= '0;
      mem_we_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_rsp_ready_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef TARTARUGA_DCACHE_PLRU_EN
        plru_q[s]  <= '0;
`endif
      end
`ifndef TARTARUGA_DCACHE_PLRU_EN
      rr_q <= '0;
`endif
    end else begin
      state_q         <= state_d;
      victim_q        <= victim_d;
      miss_addr_q     <= miss_addr_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_wr_q   <= mem_data_wr_d;
      mem_we_q        <= mem_we_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_rsp_ready_q <= mem_rsp_ready_d;
      if (hit && we_i) dirty_q[req_idx][hit_way] <= 1'b1;
      if (install) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        dirty_q[miss_idx][victim_q] <= 1'b0;
      end
`ifdef TARTARUGA_DCACHE_PLRU_EN
      if (hit) plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
      else if (install) plru_q[miss_idx] <= plru_touch(plru_q[miss_idx], victim_q);
`else
      if (install) rr_q <= rr_q + WAY_W'(1);
`endif
    end
  end

  // Tag and line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (hit && we_i) line_q[req_idx][hit_way][{req_word, 5'b0} +: 32] <= data_wr_i;
    if (install) begin
      line_q[miss_idx][victim_q] <= mem_data_line_i;
      tag_q[miss_idx][victim_q]  <= miss_addr_q[IDX_W +: TAG_W];
    end
  end

  assign mem_addr_o      = mem_addr_q;
  assign mem_data_wr_o   = mem_data_wr_q;
  assign mem_we_o        = mem_we_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_rsp_ready_o = mem_rsp_ready_q;
endmodule

// File: tb/tb_assoc_dcache.sv
// tb/tb_assoc_dcache.sv - scoreboard bench for assoc_dcache with a line-wide memory model
// Expectations follow TARTARUGA_DCACHE_PLRU_EN when it is defined for the build.
module tb_assoc_dcache;
  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic [31:0]  addr_i = '0, data_wr_i = '0;
  logic         we_i = 1'b0, valid_i = 1'b0;
  logic [31:0]  data_rd_o, mem_addr_o;
  logic         ready_o, mem_req_valid_o, mem_we_o, mem_rsp_ready_o;
  logic         mem_req_ready_i, mem_rsp_valid_i;
  logic [127:0] mem_data_wr_o, mem_data_line_i;

  assoc_dcache dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .addr_i(addr_i), .data_wr_i(data_wr_i), .we_i(we_i),
    .valid_i(valid_i), .data_rd_o(data_rd_o), .ready_o(ready_o), .mem_addr_o(mem_addr_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
    .mem_data_wr_o(mem_data_wr_o), .mem_data_line_i(mem_data_line_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [127:0] line;
  } req_t;

  req_t         req_exp_q[$];
  logic [31:0]  exp_rd_q[$];
  logic [127:0] mem_img[logic [31:0]];
  logic [31:0]  ref_words[logic [31:0]];
  int           n_chk = 0, n_pass = 0;
  int           stall_left = 0, req_cnt = 0;
  logic         hold_rsp = 1'b0, rsp_pending = 1'b0;
  logic [127:0] rsp_line = '0;
  req_t         cur;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] la);
    for (int w = 0; w < 4; w++) init_line[32*w +: 32] = {la[23:0], 8'(w)} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] la);
    return mem_img.exists(la) ? mem_img[la] : init_line(la);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  wa;
    wa = {a[31:2], 2'b00};
    if (ref_words.exists(wa)) return ref_words[wa];
    l = line_of({a[31:4], 4'h0});
    return l[32*int'(a[3:2]) +: 32];
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] la);
    for (int w = 0; w < 4; w++) model_line[32*w +: 32] = model_word(la + 32'(4*w));
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic w);
    mk_req.addr = a;
    mk_req.we   = w;
    mk_req.line = w ? model_line(a) : '0;
  endfunction

  // Memory: accepts requests against the expected-request queue, answers refills one cycle later.
  initial begin
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_data_line_i = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rstn_i) begin
        rsp_pending     = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
      end else begin
        mem_rsp_valid_i = rsp_pending && !hold_rsp;
        mem_data_line_i = rsp_pending ? rsp_line : '1;
        mem_req_ready_i = (stall_left == 0);
        #1;
        if (mem_rsp_valid_i && mem_rsp_ready_o) rsp_pending = 1'b0;
        if (mem_req_valid_o) begin
          if (req_exp_q.size() == 0) begin
            chk("req_expected", 128'(req_exp_q.size()), 128'd1);
          end else begin
            cur = req_exp_q[0];
            chk("req_addr", mem_addr_o, cur.addr);
            chk("req_we", mem_we_o, cur.we);
            if (cur.we) chk("wb_line", mem_data_wr_o, cur.line);
            if (mem_req_ready_i) begin
              void'(req_exp_q.pop_front());
              req_cnt++;
              if (cur.we) mem_img[cur.addr] = cur.line;
              else begin
                rsp_pending = 1'b1;
                rsp_line    = line_of(cur.addr);
              end
            end else if (stall_left > 0) stall_left--;
          end
        end
      end
    end
  end

  // Load results are popped from the scoreboard whenever the DUT completes a load.
  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      if (rstn_i && valid_i && ready_o && !we_i) begin
        if (exp_rd_q.size() == 0) chk("rd_expected", 128'(exp_rd_q.size()), 128'd1);
        else chk("rd_data", data_rd_o, exp_rd_q.pop_front());
      end else if (rstn_i && valid_i && !ready_o) begin
        chk("rd_zero_when_busy", data_rd_o, 32'h0);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int exp_lat, input string tag);
    int cyc;
    @(negedge clk_i);
    addr_i = a; we_i = w; data_wr_i = d; valid_i = 1'b1;
    if (w) ref_words[{a[31:2], 2'b00}] = d;
    else exp_rd_q.push_back(model_word(a));
    cyc = 0;
    #3;
    while (!ready_o && cyc < 200) begin
      @(negedge clk_i);
      #3;
      cyc++;
    end
    chk({tag, "_ready"}, ready_o, 1'b1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    we_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    valid_i = 1'b0;
    we_i = 1'b0;
    #3;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_rd", data_rd_o, 32'h0);
    chk("rst_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_data_wr_o, 128'h0);
    chk("rst_rsp_ready", mem_rsp_ready_o, 1'b0);
    req_exp_q.delete();
    exp_rd_q.delete();
    ref_words.delete();
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  initial begin
    int n;
    do_reset();

    mem_img[32'h1000] = 128'h0123456789ABCDEF0123456789ABCDEF;
    mem_img[32'h4000] = 128'hFEDCBA9876543210FEDCBA9876543210;
    chk("spec_word_1000", model_word(32'h1000), 32'h89ABCDEF);
    req_exp_q.push_back(mk_req(32'h1000, 1'b0));
    do_req(32'h1000, 1'b0, 32'h0, 3, "ld_1000");

    n = req_cnt;
    do_req(32'h1000, 1'b0, 32'h0, 0, "reld_1000");
    chk("reld_no_mem_req", 128'(req_cnt), 128'(n));

    stall_left = 3;
    req_exp_q.push_back(mk_req(32'h4000, 1'b0));
    do_req(32'h4008, 1'b1, 32'h01234567, 6, "st_4008");
    do_req(32'h4008, 1'b0, 32'h0, 0, "ld_4008");
    do_req(32'h4000, 1'b0, 32'h0, 0, "ld_4000");

    req_exp_q.push_back(mk_req(32'h5000, 1'b0));
    do_req(32'h5000, 1'b0, 32'h0, 3, "ld_5000");
    cur = mk_req(32'h4000, 1'b1);
    chk("spec_wb_word2", cur.line[95:64], 32'h01234567);
    req_exp_q.push_back(cur);
    req_exp_q.push_back(mk_req(32'h6000, 1'b0));
    do_req(32'h6000, 1'b0, 32'h0, 4, "ld_6000_dirty");

    do_reset();
    for (int i = 1; i <= 2; i++) begin
      req_exp_q.push_back(mk_req(32'(i) << 12, 1'b0));
      do_req(32'(i) << 12, 1'b0, 32'h0, 3, "fill_set0");
    end
    do_req(32'h1000, 1'b0, 32'h0, 0, "rehit_1000");
    req_exp_q.push_back(mk_req(32'h3000, 1'b0));
    do_req(32'h3000, 1'b0, 32'h0, 3, "ld_3000");
`ifdef TARTARUGA_DCACHE_PLRU_EN
    do_req(32'h1000, 1'b0, 32'h0, 0, "plru_keeps_1000");
`else
    req_exp_q.push_back(mk_req(32'h1000, 1'b0));
    do_req(32'h1000, 1'b0, 32'h0, 3, "rr_evicted_1000");
`endif
    req_exp_q.push_back(mk_req(32'h2000, 1'b0));
    do_req(32'h2000, 1'b0, 32'h0, 3, "ld_2000_evicted");

    do_reset();
    hold_rsp = 1'b1;
    req_exp_q.push_back(mk_req(32'h1000, 1'b0));
    @(negedge clk_i);
    addr_i = 32'h1000; we_i = 1'b0; valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (mem_rsp_ready_o) break;
      @(negedge clk_i);
    end
    chk("reached_refill_wait", mem_rsp_ready_o, 1'b1);
    do_reset();
    hold_rsp = 1'b0;
    req_exp_q.push_back(mk_req(32'h1000, 1'b0));
    do_req(32'h1000, 1'b0, 32'h0, 3, "ld_after_abort");

    repeat (5) @(negedge clk_i);
    chk("req_q_drained", 128'(req_exp_q.size()), 128'd0);
    chk("rd_q_drained", 128'(exp_rd_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
